pcie_cpld_tx: RTL and testbench

//  Transmit-side completer for BAR memory reads. Takes one decoded MRd request at a time
//  and builds a 3DW CplD TLP (payload read from BAR RAM) or a payload-less UR Cpl.

---
 rtl/pcie_cpld_tx_pkg.sv | 44 ++++
 rtl/pcie_cpld_tx_skid.sv | 37 +++
 rtl/pcie_cpld_tx.sv | 155 +++++++++++++++
 tb/tb_pcie_cpld_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_cpld_tx_pkg.sv
// Shared codes and header-word builder for the BAR-read completion transmitter.
package pcie_cpld_tx_pkg;

    localparam logic [2:0] FMT_CPL   = 3'b000;
    localparam logic [2:0] FMT_CPLD  = 3'b010;
    localparam logic [4:0] TYPE_CPL  = 5'b01010;
    localparam logic [2:0] STATUS_SC = 3'b000;
    localparam logic [2:0] STATUS_UR = 3'b001;
    localparam int unsigned HDR_WORDS = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_HDR,
        S_PAY
    } state_t;

    typedef struct packed {
        logic [15:0] id;
        logic [7:0]  tag;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [9:0]  len;
        logic [6:0]  lower_addr;
        logic        ur;
    } req_t;

    // 16-bit header word idx (0..5) of a 3DW Cpl/CplD, upper DW half first.
    function automatic logic [15:0] hdr_word(input logic [2:0] idx, input req_t r,
                                             input logic [15:0] cpl_id);
        logic [15:0] w;
        case (idx)
            3'd0:    w = {(r.ur ? FMT_CPL : FMT_CPLD), TYPE_CPL, 1'b0, r.tc, 4'b0000};
            3'd1:    w = {2'b00, r.attr, 2'b00, (r.ur ? 10'd0 : r.len)};
            3'd2:    w = cpl_id;
            3'd3:    w = {(r.ur ? STATUS_UR : STATUS_SC), 1'b0,
                          (r.ur ? 12'd4 : {r.len, 2'b00})};
            3'd4:    w = r.id;
            default: w = {r.tag, 1'b0, r.lower_addr};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pcie_cpld_tx_skid.sv
// One-entry skid buffer on the BAR RAM read-data path.
// A word read while the transmit side is stalled is parked here until taken.
module cpld_skid
    import pcie_cpld_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic [15:0] ram_data,
    input  logic        take,
    output logic [15:0] data
);

    logic        pending;
    logic        skid_valid;
    logic [15:0] skid;

    // Track the in-flight RAM word and park it when it is not consumed on arrival.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= 1'b0;
            skid_valid <= 1'b0;
            skid       <= '0;
        end else begin
            pending <= rd_en;
            if (take) begin
                skid_valid <= 1'b0;
            end else if (pending) begin
                skid       <= ram_data;
                skid_valid <= 1'b1;
            end
        end
    end

    assign data = skid_valid ? skid : ram_data;

endmodule

// File: rtl/pcie_cpld_tx.sv
// Transmit-side completer for BAR memory reads: builds a CplD (or UR Cpl)
// and streams it onto the 16-bit core transmit interface.
module pcie_cpld_tx
    import pcie_cpld_tx_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD_DW = 32,
    parameter int unsigned RAM_AW         = 12
) (
    input  logic              clk_125,
    input  logic              sys_rst,
    input  logic [7:0]        bus_num,
    input  logic [4:0]        dev_num,
    input  logic [2:0]        func_num,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [15:0]       req_id,
    input  logic [7:0]        req_tag,
    input  logic [2:0]        req_tc,
    input  logic [1:0]        req_attr,
    input  logic [9:0]        req_len,
    input  logic [RAM_AW-1:0] req_addr,
    output logic              ram_rd_en,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [15:0]       ram_data,
    output logic              tx_req,
    input  logic              tx_rdy,
    output logic              tx_st,
    output logic              tx_end,
    output logic [15:0]       tx_data
);

    localparam logic [11:0] HDR_WORDS_W = 12'(HDR_WORDS);

    state_t            state;
    req_t              req;
    logic [11:0]       wcnt;
    logic [11:0]       last_idx;
    logic [11:0]       fetch_cnt;
    logic [11:0]       pay_words;
    logic [RAM_AW-1:0] faddr;
    logic [15:0]       skid_data;
    logic [15:0]       cpl_id;
    logic [11:0]       next_idx;
    logic              in_fetch_window;
    logic              take;
    logic [10:0]       len_eff;
    logic              is_ur;
    logic [11:0]       pay_words_in;

    assign cpl_id   = {bus_num, dev_num, func_num};
    assign next_idx = wcnt + 12'd1;
    assign ram_addr = faddr;

    // Decode the incoming request: effective length and whether it must be refused.
    always_comb begin
        len_eff      = (req_len == 10'd0) ? 11'd1024 : {1'b0, req_len};
        is_ur        = 32'(len_eff) > MAX_PAYLOAD_DW;
        pay_words_in = is_ur ? 12'd0 : {len_eff, 1'b0};
    end

    // Prefetch runs two words ahead of the output register, starting at header word 4,
    // and only advances on cycles the core accepts a word, so at most one word is in flight.
    always_comb begin
        in_fetch_window = ((state == S_HDR) && (wcnt >= 12'd4)) || (state == S_PAY);
        ram_rd_en       = !sys_rst && tx_rdy && in_fetch_window && !req.ur
                          && (fetch_cnt != pay_words);
        take            = tx_rdy && ((state == S_HDR) || (state == S_PAY)) && !tx_end
                          && (next_idx >= HDR_WORDS_W);
    end

    cpld_skid u_skid (
        .clk      (clk_125),
        .rst      (sys_rst),
        .rd_en    (ram_rd_en),
        .ram_data (ram_data),
        .take     (take),
        .data     (skid_data)
    );

    // Request/arbitration/header/payload sequencer with registered transmit outputs.
    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            req       <= '0;
            req_ready <= 1'b1;
            tx_req    <= 1'b0;
            tx_st     <= 1'b0;
            tx_end    <= 1'b0;
            tx_data   <= '0;
            wcnt      <= '0;
            last_idx  <= '0;
            fetch_cnt <= '0;
            pay_words <= '0;
            faddr     <= '0;
        end else begin
            if (ram_rd_en) begin
                faddr     <= faddr + 1'b1;
                fetch_cnt <= fetch_cnt + 12'd1;
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req.id         <= req_id;
                        req.tag        <= req_tag;
                        req.tc         <= req_tc;
                        req.attr       <= req_attr;
                        req.len        <= req_len;
                        req.lower_addr <= {req_addr[5:0], 1'b0};
                        req.ur         <= is_ur;
                        pay_words      <= pay_words_in;
                        last_idx       <= 12'd5 + pay_words_in;
                        faddr          <= req_addr;
                        fetch_cnt      <= '0;
                        wcnt           <= '0;
                        req_ready      <= 1'b0;
                        tx_req         <= 1'b1;
                        state          <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (tx_rdy) begin
                        tx_req  <= 1'b0;
                        tx_st   <= 1'b1;
                        tx_end  <= 1'b0;
                        tx_data <= hdr_word(3'd0, req, cpl_id);
                        wcnt    <= '0;
                        state   <= S_HDR;
                    end
                end
                default: begin
                    if (tx_rdy) begin
                        if (tx_end) begin
                            tx_end    <= 1'b0;
                            tx_st     <= 1'b0;
                            tx_data   <= '0;
                            req_ready <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            wcnt    <= next_idx;
                            tx_st   <= 1'b0;
                            tx_end  <= (next_idx == last_idx);
                            if (next_idx < HDR_WORDS_W) begin
                                tx_data <= hdr_word(next_idx[2:0], req, cpl_id);
                            end else begin
                                tx_data <= skid_data;
                                state   <= S_PAY;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_cpld_tx.sv
// Directed bench for pcie_cpld_tx: BAR RAM model, packet collector, hand-computed headers.
module tb_pcie_cpld_tx;

    logic        clk_125 = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  bus_num = 8'h12;
    logic [4:0]  dev_num = 5'h03;
    logic [2:0]  func_num = 3'h5;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_id = '0;
    logic [7:0]  req_tag = '0;
    logic [2:0]  req_tc = '0;
    logic [1:0]  req_attr = '0;
    logic [9:0]  req_len = '0;
    logic [11:0] req_addr = '0;
    logic        ram_rd_en;
    logic [11:0] ram_addr;
    logic [15:0] ram_data = '0;
    logic        tx_req;
    logic        tx_rdy = 1'b0;
    logic        tx_st;
    logic        tx_end;
    logic [15:0] tx_data;

    always #5 clk_125 = ~clk_125;

    pcie_cpld_tx #(.MAX_PAYLOAD_DW(32), .RAM_AW(12)) dut (
        .clk_125   (clk_125),
        .sys_rst   (sys_rst),
        .bus_num   (bus_num),
        .dev_num   (dev_num),
        .func_num  (func_num),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_id    (req_id),
        .req_tag   (req_tag),
        .req_tc    (req_tc),
        .req_attr  (req_attr),
        .req_len   (req_len),
        .req_addr  (req_addr),
        .ram_rd_en (ram_rd_en),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .tx_req    (tx_req),
        .tx_rdy    (tx_rdy),
        .tx_st     (tx_st),
        .tx_end    (tx_end),
        .tx_data   (tx_data)
    );

    // BAR RAM: distinct contents per address, one-cycle read latency.
    logic [15:0] mem [0:4095];
    initial for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 40503) ^ 16'h3C5A;
    always @(posedge clk_125) if (ram_rd_en) ram_data <= mem[ram_addr];

    int errors = 0;
    int checks = 0;

    logic [15:0] words[$];
    logic        st_q[$];
    logic        end_q[$];
    logic [11:0] addrs[$];
    int hold_err, rd_err, treq_cycles;
    bit timed_out, aborted;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input int k);
        return (k < words.size()) ? words[k] : 16'hxxxx;
    endfunction

    task automatic send_req(input logic [9:0] len, input logic [11:0] addr, input logic [7:0] tag,
                            input logic [2:0] tc, input logic [1:0] attr, input logic [15:0] id,
                            input bit hold);
        bit r;
        bit acc = 0;
        #1;
        req_len = len; req_addr = addr; req_tag = tag; req_tc = tc; req_attr = attr; req_id = id;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            r = req_ready;
            @(posedge clk_125);
            if (r) begin acc = 1; break; end
            #1;
        end
        check("req_accept", 32'(acc), 32'd1);
        if (!hold) begin
            #1;
            req_valid = 1'b0;
        end
    endtask

    // mode 0: rdy always 1; 1: rdy toggles 1/0; 2: rdy 0 for three cycles then 1.
    // rst_at >= 0: assert sys_rst while that word index is on the bus.
    task automatic collect(input int mode, input int rst_at);
        bit in_pkt = 0;
        bit done = 0;
        bit prev_hold = 0;
        logic [15:0] prev_data = '0;
        words.delete(); st_q.delete(); end_q.delete(); addrs.delete();
        hold_err = 0; rd_err = 0; treq_cycles = 0; aborted = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            #1;
            case (mode)
                0:       tx_rdy = 1'b1;
                1:       tx_rdy = (cyc % 2 == 0);
                default: tx_rdy = (cyc >= 3);
            endcase
            #1;
            if (tx_req) treq_cycles++;
            if (ram_rd_en) begin
                addrs.push_back(ram_addr);
                if (!tx_rdy) rd_err++;
            end
            if (!in_pkt && tx_st) in_pkt = 1;
            if (in_pkt && prev_hold && tx_data !== prev_data) hold_err++;
            if (in_pkt && rst_at == words.size()) begin
                sys_rst = 1'b1;
                aborted = 1;
                @(posedge clk_125);
                #1;
                sys_rst = 1'b0;
                done = 1;
            end else begin
                if (in_pkt && tx_rdy) begin
                    words.push_back(tx_data);
                    st_q.push_back(tx_st);
                    end_q.push_back(tx_end);
                    if (tx_end) done = 1;
                end
                prev_hold = in_pkt && !tx_rdy;
                prev_data = tx_data;
                @(posedge clk_125);
            end
        end
        timed_out = !done;
        check("collect_timeout", 32'(timed_out), 32'd0);
    endtask

    task automatic check_frame(input string tag, input int nwords);
        int nst = 0;
        int nend = 0;
        foreach (st_q[i]) nst += int'(st_q[i]);
        foreach (end_q[i]) nend += int'(end_q[i]);
        check({tag, "_nwords"}, 32'(words.size()), 32'(nwords));
        check({tag, "_st_first"}, 32'((st_q.size() > 0) ? st_q[0] : 1'b0), 32'd1);
        check({tag, "_st_count"}, 32'(nst), 32'd1);
        check({tag, "_end_last"}, 32'((end_q.size() > 0) ? end_q[end_q.size()-1] : 1'b0), 32'd1);
        check({tag, "_end_count"}, 32'(nend), 32'd1);
    endtask

    task automatic check_payload(input string tag, input logic [11:0] base, input int npay);
        int bad = 0;
        for (int i = 0; i < npay; i++) begin
            logic [11:0] a;
            a = base + 12'(i);
            if (6 + i >= words.size() || words[6 + i] !== mem[a]) bad++;
        end
        check({tag, "_payload_bad"}, 32'(bad), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_125);
        #1 sys_rst = 1'b0;
        #1;
        check("rst_outputs", {12'd0, tx_req, tx_st, tx_end, ram_rd_en, tx_data}, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk_125);

        // 1: len=1, addr 0x010, tag 0x5A, rdy always 1
        send_req(10'd1, 12'h010, 8'h5A, 3'd3, 2'd2, 16'hBEEF, 0);
        collect(0, -1);
        check_frame("t1", 8);
        check("t1_w0", word_at(0), 16'h4A30);
        check("t1_w1", word_at(1), 16'h2001);
        check("t1_w2", word_at(2), 16'h121D);
        check("t1_w3", word_at(3), 16'h0004);
        check("t1_w4", word_at(4), 16'hBEEF);
        check("t1_w5", word_at(5), 16'h5A20);
        check_payload("t1", 12'h010, 2);

        // 2: len=32 (= max), tx_rdy toggling
        send_req(10'd32, 12'h200, 8'h33, 3'd0, 2'd0, 16'h0100, 0);
        collect(1, -1);
        check_frame("t2", 70);
        check("t2_w0", word_at(0), 16'h4A00);
        check("t2_w1", word_at(1), 16'h0020);
        check("t2_w3", word_at(3), 16'h0080);
        check("t2_w5", word_at(5), 16'h3300);
        check_payload("t2", 12'h200, 64);
        check("t2_hold_err", 32'(hold_err), 32'd0);
        check("t2_rd_when_stalled", 32'(rd_err), 32'd0);
        check("t2_nreads", 32'(addrs.size()), 32'd64);

        // 3: len=33 -> UR Cpl
        send_req(10'd33, 12'h123, 8'h11, 3'd1, 2'd0, 16'h0200, 0);
        collect(0, -1);
        check_frame("t3", 6);
        check("t3_w0", word_at(0), 16'h0A10);
        check("t3_w1", word_at(1), 16'h0000);
        check("t3_w3", word_at(3), 16'h2004);
        check("t3_w5", word_at(5), 16'h1146);
        check("t3_nreads", 32'(addrs.size()), 32'd0);

        // 4: address wrap
        send_req(10'd2, 12'hFFE, 8'h44, 3'd0, 2'd1, 16'h0300, 0);
        collect(0, -1);
        check_frame("t4", 10);
        check("t4_w1", word_at(1), 16'h1002);
        check("t4_w3", word_at(3), 16'h0008);
        check("t4_w5", word_at(5), 16'h447C);
        check("t4_nreads", 32'(addrs.size()), 32'd4);
        check("t4_a0", 32'((addrs.size() > 0) ? addrs[0] : 12'hxxx), 32'hFFE);
        check("t4_a1", 32'((addrs.size() > 1) ? addrs[1] : 12'hxxx), 32'hFFF);
        check("t4_a2", 32'((addrs.size() > 2) ? addrs[2] : 12'hxxx), 32'h000);
        check("t4_a3", 32'((addrs.size() > 3) ? addrs[3] : 12'hxxx), 32'h001);
        check_payload("t4", 12'hFFE, 4);

        // 5: reset on payload word 10, then a clean request
        send_req(10'd16, 12'h300, 8'h55, 3'd0, 2'd0, 16'h0400, 0);
        collect(0, 16);
        check("t5_aborted", 32'(aborted), 32'd1);
        #1;
        check("t5_outputs_zero", {8'd0, tx_req, tx_st, tx_end, ram_rd_en, ram_addr, tx_data}, 32'd0);
        check("t5_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk_125);
        send_req(10'd1, 12'h040, 8'h77, 3'd2, 2'd0, 16'h0500, 0);
        collect(0, -1);
        check_frame("t5b", 8);
        check("t5b_w0", word_at(0), 16'h4A20);
        check("t5b_w5", word_at(5), 16'h7700);
        check_payload("t5b", 12'h040, 2);

        // 6: back-to-back requests, second held in ARB until tx_rdy
        send_req(10'd4, 12'h080, 8'h01, 3'd0, 2'd0, 16'h0600, 1);
        #1;
        req_len = 10'd2; req_addr = 12'h0A0; req_tag = 8'h02; req_id = 16'h0700;
        collect(0, -1);
        check_frame("t6a", 14);
        check_payload("t6a", 12'h080, 8);
        #2;
        check("t6_ready_after_end", 32'(req_ready), 32'd1);
        @(posedge clk_125);
        #1 req_valid = 1'b0;
        collect(2, -1);
        check("t6_treq_cycles", 32'(treq_cycles), 32'd4);
        check_frame("t6b", 10);
        check("t6b_w5", word_at(5), 16'h0240);
        check_payload("t6b", 12'h0A0, 4);

        // 7: len=0 encodes 1024 -> UR with this MAX
        send_req(10'd0, 12'h000, 8'h09, 3'd0, 2'd0, 16'h0800, 0);
        collect(0, -1);
        check_frame("t7", 6);
        check("t7_w1", word_at(1), 16'h0000);
        check("t7_w3", word_at(3), 16'h2004);
        check("t7_nreads", 32'(addrs.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
